rgb_sgen: RTL and testbench
===========================

# rgb_sgen

Parametrised, synthesizable SK6812/WS2812-style serial waveform generator. It converts handshaked LED words into a one-wire pulse stream with programmable bit timing, word width and stream-reset level. Each frame ends with a "stream reset" hold. It serves as the on-chip self-test source feeding `rgb_sinp`. It is also a generalised successor to the fixed-format output path.

## Interface
- `WORD_BITS`, 24: bits per LED word (1..32), sent MSB first.
- `T0H`, 16: high clocks for a 0 bit (>=1).
- `T0L`, 74: low clocks for a 0 bit (>=1).
- `T1H`, 45: high clocks for a 1 bit (>=1).
- `T1L`, 45: low clocks for a 1 bit (>=1).
- `RST_CLKS`, 7681: stream-reset hold clocks (>=1).
- `COUNTER_MAX`, 7800: timer ceiling. It must be >= every timing parameter, else elaboration error.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_word`  in  WORD_BITS  word to send.
- `in_valid`  in  1  word available.
- `in_frame_end`  in  1  sampled with the word; a stream reset follows this word.
- `in_rst_level`  in  1  sampled with the word; the level driven during the stream reset.
- `in_stretch`  in  8  extra high clocks per bit. Used only under `RGB_SGEN_STRETCH_EN`.
- `out_ready`  out  1  generator accepts a word this cycle.
- `out_sig`  out  1  serial output.
- `out_busy`  out  1  state != IDLE.
- `out_word_done`  out  1  one-cycle strobe.
- `out_frame_done`  out  1  one-cycle strobe.

## Operation
- States: IDLE, HIGH, LOW, RST_HOLD.
- Handshake: a word is accepted on a rising edge with `in_valid && out_ready`. At accept, the generator latches the word, `in_frame_end`, `in_rst_level` and `in_stretch`. Later changes to these inputs are ignored.
- IDLE → HIGH on accept. The bit counter loads WORD_BITS-1 and the timer loads TxH-1 for the word's MSB.
- HIGH → LOW when the timer reaches 0. The timer loads TxL-1.
- LOW, timer at 0, bits remaining → HIGH for the next bit.
- LOW, timer at 0, last bit:
  - → RST_HOLD if frame_end was latched (timer loads RST_CLKS-1).
  - Otherwise → HIGH if a new word is accepted in that cycle.
  - Otherwise → IDLE.
- RST_HOLD, timer at 0 → IDLE.
- `out_ready` is combinational from state. It is 1 in IDLE. It is also 1 in the final LOW cycle of the last bit when frame_end is not latched. It is 0 everywhere else.
- `out_sig` by state: 1 in HIGH, 0 in LOW, the latched rst_level in RST_HOLD, 0 in IDLE.
- Timer width is $clog2(COUNTER_MAX+1).
- Reset values: `out_sig`=0, `out_ready`=1, `out_busy`=0, both strobes 0, state IDLE.

## Timing
- Accept at edge N: `out_sig` rises in cycle N+1.
- Each bit lasts exactly TxH (+stretch) high cycles, then TxL low cycles.
- A word lasts the sum of its bit periods, with no gaps between bits.
- Back-to-back words: if accepted in the final LOW cycle, the next HIGH starts the following cycle with zero idle cycles.
- `out_word_done` pulses in the final LOW cycle of every word.
- `out_frame_done` pulses in the final RST_HOLD cycle. IDLE and `out_ready`=1 follow on the next cycle.
- `in_valid` asserted while `out_ready`=0 has no effect. The word must be held by the source until accepted.
- Asserting `rst_n` mid-word or mid-hold forces `out_sig`=0 immediately (asynchronously). The partial word is discarded and no strobes fire.

## Configuration
- `RGB_SGEN_STRETCH_EN` defined:
  - HIGH lasts TxH + latched `in_stretch` cycles. LOW is unchanged.
  - Elaboration requires COUNTER_MAX >= max(T0H,T1H)+255.
  - Used for sweeping `rgb_sinp` min/max acceptance windows.
- Not defined: `in_stretch` is ignored, the stretch adder and latch are not built, and HIGH lasts exactly TxH.

## Structure
- Shared package `rgb_pkg` holds:
  - the state encoding constants;
  - the SK6812 default timings at 96 MHz (16/74/45/45/7681);
  - `RGB_WORD_BITS_GRB`=24 and `RGB_WORD_BITS_RGBW`=32.
- One sub-module, `rgb_sgen_timer`: a loadable down-counter with load value, load strobe and `zero` flag, parameterised by COUNTER_MAX.
- Shift register, bit counter and FSM stay in `rgb_sgen`.

## Test plan
All scenarios use WORD_BITS=8, T0H=2, T0L=6, T1H=4, T1L=4, RST_CLKS=20.
- **Single word with frame end:** 8'hA5, frame_end=1, rst_level=0 → high widths 4,2,4,2,2,4,2,4. The word spans 64 cycles. `out_word_done` pulses at cycle 64. `out_sig` is low for 20 cycles, then `out_frame_done` pulses. `out_ready` returns to 1.
- **Back-to-back words:** 8'hFF then 8'h00 with `in_valid` held → 128 contiguous cycles. `out_ready` is 1 in exactly one cycle mid-stream (cycle 64). There is no idle gap between words.
- **High stream reset:** rst_level=1, frame_end=1 → `out_sig` is high for 20 cycles after the last LOW, then 0. `out_busy` falls with `out_frame_done`+1.
- **Async reset mid-bit:** `rst_n` asserted in the third HIGH cycle of a 1 bit → `out_sig`=0 in the same cycle, `out_ready`=1, no strobes. A new word then starts cleanly.
- **Stretch:** in_stretch=3 with macro defined → 1-bit high lasts 7 cycles and 0-bit high lasts 5. With the macro undefined, the same stimulus gives 4 and 2.
- **Input changes while busy:** `in_word` changes while busy → the output is unaffected. `in_valid` held while `out_ready`=0 → no extra word is sent.

Source files
------------

// File: rtl/rgb_pkg.sv
// -----------------------------------------------------------------------------
// rgb_pkg
// Shared definitions for the RGB serial LED path.
//   - rgb_state_e     : generator state encoding (IDLE, HIGH, LOW, RST_HOLD)
//   - RGB_*_96M       : SK6812 default bit timings in 96 MHz clocks
//   - RGB_WORD_BITS_* : word widths for GRB (24) and RGBW (32) LEDs
//   - rgb_max()       : helper used by elaboration-time parameter checks
// No ports.
// -----------------------------------------------------------------------------
package rgb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HIGH     = 2'd1,
    ST_LOW      = 2'd2,
    ST_RST_HOLD = 2'd3
  } rgb_state_e;

  localparam int unsigned RGB_T0H_96M      = 16;
  localparam int unsigned RGB_T0L_96M      = 74;
  localparam int unsigned RGB_T1H_96M      = 45;
  localparam int unsigned RGB_T1L_96M      = 45;
  localparam int unsigned RGB_RST_CLKS_96M = 7681;

  localparam int unsigned RGB_WORD_BITS_GRB  = 24;
  localparam int unsigned RGB_WORD_BITS_RGBW = 32;

  function automatic int unsigned rgb_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rgb_sgen_timer.sv
// -----------------------------------------------------------------------------
// rgb_sgen_timer
// Loadable down-counter that times every phase of the serial waveform.
// A load has priority; otherwise the count decrements and parks at zero.
// Ports:
//   clk        in  clock, rising edge
//   rst_n      in  asynchronous active-low reset
//   i_load     in  load strobe
//   i_load_val in  value loaded (phase length - 1)
//   o_zero     out count is zero (last cycle of the current phase)
// -----------------------------------------------------------------------------
module rgb_sgen_timer #(
  parameter  int unsigned COUNTER_MAX = 7800,
  localparam int unsigned TW          = $clog2(COUNTER_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  output logic          o_zero
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/rgb_sgen.sv
// -----------------------------------------------------------------------------
// rgb_sgen
// SK6812/WS2812-style one-wire waveform generator. Accepts LED words over a
// valid/ready handshake and emits each bit MSB first as TxH high clocks then
// TxL low clocks. A word flagged frame_end is followed by a stream-reset hold
// of RST_CLKS clocks at the level latched with that word.
// Optional feature: define RGB_SGEN_STRETCH_EN to add in_stretch extra high
// clocks to every bit of a word (latched with the word).
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   in_word          word to send
//   in_valid         word available
//   in_frame_end     stream reset follows this word
//   in_rst_level     line level during the stream reset
//   in_stretch       extra high clocks per bit (stretch build only)
//   out_ready        generator accepts a word this cycle
//   out_sig          serial output
//   out_busy         generator not idle
//   out_word_done    strobe in the final LOW cycle of each word
//   out_frame_done   strobe in the final stream-reset cycle
// -----------------------------------------------------------------------------
module rgb_sgen
  import rgb_pkg::*;
#(
  parameter int unsigned WORD_BITS   = RGB_WORD_BITS_GRB,
  parameter int unsigned T0H         = RGB_T0H_96M,
  parameter int unsigned T0L         = RGB_T0L_96M,
  parameter int unsigned T1H         = RGB_T1H_96M,
  parameter int unsigned T1L         = RGB_T1L_96M,
  parameter int unsigned RST_CLKS    = RGB_RST_CLKS_96M,
  parameter int unsigned COUNTER_MAX = 7800
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_BITS-1:0] in_word,
  input  logic                 in_valid,
  input  logic                 in_frame_end,
  input  logic                 in_rst_level,
  input  logic [7:0]           in_stretch,
  output logic                 out_ready,
  output logic                 out_sig,
  output logic                 out_busy,
  output logic                 out_word_done,
  output logic                 out_frame_done
);

  localparam int unsigned TW = $clog2(COUNTER_MAX + 1);
  localparam int unsigned BW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

`ifdef RGB_SGEN_STRETCH_EN
  localparam int unsigned HIGH_MAX = rgb_max(T0H, T1H) + 255;
`else
  localparam int unsigned HIGH_MAX = rgb_max(T0H, T1H);
`endif
  localparam int unsigned TIME_MAX =
    rgb_max(rgb_max(HIGH_MAX, rgb_max(T0L, T1L)), RST_CLKS);

  if (WORD_BITS < 1 || WORD_BITS > 32) begin : g_bad_word_bits
    $error("rgb_sgen: WORD_BITS must be 1..32");
  end
  if (T0H < 1 || T0L < 1 || T1H < 1 || T1L < 1 || RST_CLKS < 1) begin : g_bad_timing
    $error("rgb_sgen: all timing parameters must be >= 1");
  end
  if (COUNTER_MAX < TIME_MAX) begin : g_bad_counter_max
    $error("rgb_sgen: COUNTER_MAX too small for the timing parameters");
  end

  localparam logic [TW-1:0] C_T0H = TW'(T0H - 1);
  localparam logic [TW-1:0] C_T0L = TW'(T0L - 1);
  localparam logic [TW-1:0] C_T1H = TW'(T1H - 1);
  localparam logic [TW-1:0] C_T1L = TW'(T1L - 1);
  localparam logic [TW-1:0] C_RST = TW'(RST_CLKS - 1);

  rgb_state_e           r_state, w_state_nx;
  logic [WORD_BITS-1:0] r_shift;
  logic [WORD_BITS-1:0] w_shift_nx;
  logic [BW-1:0]        r_bitcnt;
  logic                 r_frame_end;
  logic                 r_rst_level;
  logic                 w_tload;
  logic [TW-1:0]        w_tval;
  logic                 w_tzero;
  logic                 w_last_bit;
  logic                 w_accept;
  logic                 w_bit_adv;
  logic [TW-1:0]        w_hi_new;  // high load for a freshly accepted word
  logic [TW-1:0]        w_hi_nxt;  // high load for the next bit of this word

  function automatic logic [TW-1:0] hi_base(input logic b);
    return b ? C_T1H : C_T0H;
  endfunction

  assign w_shift_nx = r_shift << 1;
  assign w_last_bit = (r_bitcnt == '0);

`ifdef RGB_SGEN_STRETCH_EN
  logic [7:0] r_stretch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_stretch <= '0;
    else if (w_accept) r_stretch <= in_stretch;
  end

  assign w_hi_new = hi_base(in_word[WORD_BITS-1]) + TW'(in_stretch);
  assign w_hi_nxt = hi_base(w_shift_nx[WORD_BITS-1]) + TW'(r_stretch);
`else
  logic w_unused_stretch;
  assign w_unused_stretch = ^in_stretch;
  assign w_hi_new = hi_base(in_word[WORD_BITS-1]);
  assign w_hi_nxt = hi_base(w_shift_nx[WORD_BITS-1]);
`endif

  // Ready in IDLE, and in the final LOW cycle of a word that does not end a
  // frame so a waiting word continues the stream with no idle gap.
  assign out_ready = (r_state == ST_IDLE) ||
                     ((r_state == ST_LOW) && w_tzero && w_last_bit && !r_frame_end);
  assign w_accept  = in_valid && out_ready;
  assign w_bit_adv = (r_state == ST_LOW) && w_tzero && !w_last_bit;

  assign out_busy       = (r_state != ST_IDLE);
  assign out_word_done  = (r_state == ST_LOW) && w_tzero && w_last_bit;
  assign out_frame_done = (r_state == ST_RST_HOLD) && w_tzero;

  // Decoded from the state register so an asynchronous reset drops the line
  // immediately.
  always_comb begin
    out_sig = 1'b0;
    case (r_state)
      ST_HIGH:     out_sig = 1'b1;
      ST_RST_HOLD: out_sig = r_rst_level;
      default:     out_sig = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_tload    = 1'b0;
    w_tval     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nx = ST_HIGH;
          w_tload    = 1'b1;
          w_tval     = w_hi_new;
        end
      end
      ST_HIGH: begin
        if (w_tzero) begin
          w_state_nx = ST_LOW;
          w_tload    = 1'b1;
          w_tval     = r_shift[WORD_BITS-1] ? C_T1L : C_T0L;
        end
      end
      ST_LOW: begin
        if (w_tzero) begin
          if (!w_last_bit) begin
            w_state_nx = ST_HIGH;
            w_tload    = 1'b1;
            w_tval     = w_hi_nxt;
          end else if (r_frame_end) begin
            w_state_nx = ST_RST_HOLD;
            w_tload    = 1'b1;
            w_tval     = C_RST;
          end else if (w_accept) begin
            w_state_nx = ST_HIGH;
            w_tload    = 1'b1;
            w_tval     = w_hi_new;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end
      end
      ST_RST_HOLD: begin
        if (w_tzero) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitcnt    <= '0;
      r_frame_end <= 1'b0;
      r_rst_level <= 1'b0;
    end else if (w_accept) begin
      r_bitcnt    <= BW'(WORD_BITS - 1);
      r_frame_end <= in_frame_end;
      r_rst_level <= in_rst_level;
    end else if (w_bit_adv) begin
      r_bitcnt    <= r_bitcnt - BW'(1);
    end
  end

  // Word data needs no reset: it is only observed after an accept loads it.
  always_ff @(posedge clk) begin
    if (w_accept)       r_shift <= in_word;
    else if (w_bit_adv) r_shift <= w_shift_nx;
  end

  rgb_sgen_timer #(
    .COUNTER_MAX (COUNTER_MAX)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tload),
    .i_load_val (w_tval),
    .o_zero     (w_tzero)
  );

endmodule

// File: tb/tb_rgb_sgen.sv
module tb_rgb_sgen;

  localparam int WB       = 8;
  localparam int T0H      = 2;
  localparam int T0L      = 6;
  localparam int T1H      = 4;
  localparam int T1L      = 4;
  localparam int RST_CLKS = 20;
`ifdef RGB_SGEN_STRETCH_EN
  localparam bit STRETCH_ON = 1'b1;
`else
  localparam bit STRETCH_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [WB-1:0] in_word;
  logic          in_valid;
  logic          in_frame_end;
  logic          in_rst_level;
  logic [7:0]    in_stretch;
  logic          out_ready;
  logic          out_sig;
  logic          out_busy;
  logic          out_word_done;
  logic          out_frame_done;

  rgb_sgen #(
    .WORD_BITS   (WB),
    .T0H         (T0H),
    .T0L         (T0L),
    .T1H         (T1H),
    .T1L         (T1L),
    .RST_CLKS    (RST_CLKS),
    .COUNTER_MAX (300)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_word        (in_word),
    .in_valid       (in_valid),
    .in_frame_end   (in_frame_end),
    .in_rst_level   (in_rst_level),
    .in_stretch     (in_stretch),
    .out_ready      (out_ready),
    .out_sig        (out_sig),
    .out_busy       (out_busy),
    .out_word_done  (out_word_done),
    .out_frame_done (out_frame_done)
  );

  always #5 clk = ~clk;

  // Expected line behaviour, one entry per future clock cycle.
  typedef struct {
    bit sig;
    bit wd;
    bit fd;
    bit rdy;
  } ent_t;

  ent_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   acc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expand one accepted word into its cycle-by-cycle waveform.
  function automatic void push_word(input logic [WB-1:0] w, input bit fe, input bit lv,
                                    input logic [7:0] st);
    ent_t e;
    for (int i = WB - 1; i >= 0; i--) begin
      int h;
      int l;
      h = (w[i] ? T1H : T0H) + (STRETCH_ON ? int'(st) : 0);
      l = w[i] ? T1L : T0L;
      for (int j = 0; j < h; j++) begin
        e = '{1'b1, 1'b0, 1'b0, 1'b0};
        q.push_back(e);
      end
      for (int j = 0; j < l; j++) begin
        e.sig = 1'b0;
        e.wd  = (i == 0) && (j == l - 1);
        e.fd  = 1'b0;
        e.rdy = (i == 0) && (j == l - 1) && !fe;
        q.push_back(e);
      end
    end
    if (fe) begin
      for (int j = 0; j < RST_CLKS; j++) begin
        e.sig = lv;
        e.wd  = 1'b0;
        e.fd  = (j == RST_CLKS - 1);
        e.rdy = 1'b0;
        q.push_back(e);
      end
    end
  endfunction

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    ent_t e;
    bit   busy_exp;
    @(negedge clk);
    if (q.size() > 0) begin
      e        = q[0];
      busy_exp = 1'b1;
    end else begin
      e        = '{1'b0, 1'b0, 1'b0, 1'b1};
      busy_exp = 1'b0;
    end
    check_val("sig",        32'(out_sig),        32'(e.sig));
    check_val("ready",      32'(out_ready),      32'(e.rdy));
    check_val("busy",       32'(out_busy),       32'(busy_exp));
    check_val("word_done",  32'(out_word_done),  32'(e.wd));
    check_val("frame_done", 32'(out_frame_done), 32'(e.fd));
    acc = in_valid && e.rdy;
    @(posedge clk);
    if (q.size() > 0) void'(q.pop_front());
    if (acc) push_word(in_word, in_frame_end, in_rst_level, in_stretch);
    #1;
  endtask

  task automatic send(input logic [WB-1:0] w, input bit fe, input bit lv, input logic [7:0] st);
    int k;
    in_word      = w;
    in_frame_end = fe;
    in_rst_level = lv;
    in_stretch   = st;
    in_valid     = 1'b1;
    k = 0;
    acc = 1'b0;
    while (!acc && k < 400) begin
      step();
      k++;
    end
    check_val("send_accepted", 32'(acc), 32'd1);
    in_valid = 1'b0;
    // Source changes its outputs once the word is taken; the line must not care.
    in_word      = 8'($urandom);
    in_frame_end = 1'($urandom);
    in_rst_level = 1'($urandom);
    in_stretch   = 8'($urandom);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 3000) begin
      step();
      k++;
    end
    check_val("drain_done", 32'(q.size()), 32'd0);
    step();
  endtask

  initial begin
    rst_n        = 1'b1;
    in_word      = '0;
    in_valid     = 1'b0;
    in_frame_end = 1'b0;
    in_rst_level = 1'b0;
    in_stretch   = '0;
    #1 rst_n = 1'b0;
    #3;
    check_val("rst_sig",        32'(out_sig),        32'd0);
    check_val("rst_ready",      32'(out_ready),      32'd1);
    check_val("rst_busy",       32'(out_busy),       32'd0);
    check_val("rst_word_done",  32'(out_word_done),  32'd0);
    check_val("rst_frame_done", 32'(out_frame_done), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single word, frame end, low stream reset.
    send(8'hA5, 1'b1, 1'b0, 8'd0);
    drain();

    // Back-to-back words with valid held through the whole first word.
    in_word      = 8'hFF;
    in_frame_end = 1'b0;
    in_rst_level = 1'b0;
    in_stretch   = 8'd0;
    in_valid     = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 200 && !acc; k++) step();
    check_val("b2b_first", 32'(acc), 32'd1);
    in_word = 8'h00;
    acc = 1'b0;
    for (int k = 0; k < 200 && !acc; k++) step();
    check_val("b2b_second", 32'(acc), 32'd1);
    in_valid = 1'b0;
    drain();

    // High stream-reset level.
    send(8'h3C, 1'b1, 1'b1, 8'd0);
    drain();

    // Asynchronous reset in the third high cycle of a 1 bit.
    send(8'h80, 1'b0, 1'b0, 8'd0);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_sig",        32'(out_sig),        32'd0);
    check_val("arst_ready",      32'(out_ready),      32'd1);
    check_val("arst_busy",       32'(out_busy),       32'd0);
    check_val("arst_word_done",  32'(out_word_done),  32'd0);
    check_val("arst_frame_done", 32'(out_frame_done), 32'd0);
    q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    send(8'h5A, 1'b1, 1'b0, 8'd0);
    drain();

    // Stretched high phases (plain widths when the stretch build is off).
    send(8'hC3, 1'b0, 1'b0, 8'd3);
    drain();

    // Randomised traffic, including back-to-back and held-valid cases.
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid) begin
        if ($urandom_range(0, 3) == 0) begin
          in_word      = 8'($urandom);
          in_frame_end = ($urandom_range(0, 3) == 0);
          in_rst_level = 1'($urandom);
          in_stretch   = 8'($urandom_range(0, 7));
          in_valid     = 1'b1;
        end else begin
          in_word = 8'($urandom);
        end
      end
      step();
      if (acc) begin
        in_valid = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
          in_word      = 8'($urandom);
          in_frame_end = ($urandom_range(0, 3) == 0);
          in_rst_level = 1'($urandom);
          in_stretch   = 8'($urandom_range(0, 7));
          in_valid     = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
